// File: rtl/dat_decimate_pkg.sv
// Shared definitions for the N-channel decimator: mode encodings, accumulator
// width derivation and the signed clip classifier used by the AVG path.
package dat_decimate_pkg;

  localparam logic MODE_PICK = 1'b0;
  localparam logic MODE_AVG  = 1'b1;

  typedef struct packed {
    logic over;
    logic under;
  } clip_t;

  function automatic int calc_aw(input int dw, input int cw);
    return dw + cw;
  endfunction

  // Reports whether v lies above or below the signed range of a dw-bit word.
  function automatic clip_t sat_to_dw(input logic signed [63:0] v, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    clip_t c;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    c.over  = (v > hi);
    c.under = (v < lo);
    return c;
  endfunction

endpackage

// File: rtl/dat_decimate_ch.sv
// One decimator channel: strobe synchroniser, group counter, accumulator and
// saturator. Produces one dout word per group of ratio strobes.
module dat_decimate_ch
  import dat_decimate_pkg::*;
#(
  parameter int DW = 16,
  parameter int CW = 16,
  parameter int SW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          din_en,
  input  logic          ch_en,
  input  logic          mode,
  input  logic [CW-1:0] ratio,
  input  logic [SW-1:0] shift,
  input  logic          sat_clr,
  output logic [DW-1:0] dout,
  output logic          dout_en,
  output logic          sat
);

  localparam int AW = calc_aw(DW, CW);

  logic                 r0, r1, r2, ev;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cfg_ratio;
  logic                 cfg_mode;
  logic [SW-1:0]        cfg_shift;
  logic signed [AW-1:0] acc;

  logic                 first, last;
  logic [CW-1:0]        eff_ratio, last_idx;
  logic                 eff_mode;
  logic [SW-1:0]        eff_shift;
  logic signed [AW-1:0] din_x, sum, shifted;
  logic signed [63:0]   wide;
  clip_t                clip;
  logic [DW-1:0]        avg_val;

  // The first event of a group uses the live config; later events use the latched copy.
  always_comb begin
    first     = (cnt == '0);
    eff_ratio = first ? ratio : cfg_ratio;
    eff_mode  = first ? mode  : cfg_mode;
    eff_shift = first ? shift : cfg_shift;
    last_idx  = (eff_ratio == '0) ? '0 : eff_ratio - CW'(1);
    last      = (cnt == last_idx);
    din_x     = {{CW{din[DW-1]}}, din};
    sum       = (first ? '0 : acc) + din_x;
    shifted   = sum >>> eff_shift;
    wide      = 64'(shifted);
    clip      = sat_to_dw(wide, DW);
    if (clip.over)
      avg_val = {1'b0, {(DW-1){1'b1}}};
    else if (clip.under)
      avg_val = {1'b1, {(DW-1){1'b0}}};
    else
      avg_val = shifted[DW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r0        <= 1'b0;
      r1        <= 1'b0;
      r2        <= 1'b0;
      ev        <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      cfg_ratio <= '0;
      cfg_mode  <= 1'b0;
      cfg_shift <= '0;
      dout      <= '0;
      dout_en   <= 1'b0;
      sat       <= 1'b0;
    end else begin
      r0      <= din_en;
      r1      <= r0;
      r2      <= r1;
      // Registering the edge detect fixes the latency at three clocks after capture.
      ev      <= ch_en & r1 & ~r2;
      dout_en <= 1'b0;
      sat     <= sat & ~sat_clr;
      if (!ch_en) begin
        cnt <= '0;
        acc <= '0;
      end else if (ev) begin
        if (first) begin
          cfg_ratio <= ratio;
          cfg_mode  <= mode;
          cfg_shift <= shift;
        end
        if (last) begin
          cnt     <= '0;
          acc     <= '0;
          dout_en <= 1'b1;
          if (eff_mode == MODE_AVG) begin
            dout <= avg_val;
            if (clip.over || clip.under)
              sat <= 1'b1;
          end else begin
            dout <= din;
          end
        end else begin
          cnt <= cnt + CW'(1);
          acc <= sum;
        end
      end
    end
  end

endmodule

// File: rtl/dat_decimate_n.sv
// N-channel decimator top: slices the flat buses and instances one
// independent channel per lane.
module dat_decimate_n
  import dat_decimate_pkg::*;
#(
  parameter int NCH = 4,
  parameter int DW  = 16,
  parameter int CW  = 16,
  parameter int SW  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH*DW-1:0] din,
  input  logic [NCH-1:0]    din_en,
  input  logic [NCH-1:0]    ch_en,
  input  logic [NCH-1:0]    mode,
  input  logic [NCH*CW-1:0] ratio,
  input  logic [NCH*SW-1:0] shift,
  output logic [NCH*DW-1:0] dout,
  output logic [NCH-1:0]    dout_en,
  output logic [NCH-1:0]    sat,
  input  logic [NCH-1:0]    sat_clr
);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    dat_decimate_ch #(
      .DW(DW),
      .CW(CW),
      .SW(SW)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .din    (din[c*DW +: DW]),
      .din_en (din_en[c]),
      .ch_en  (ch_en[c]),
      .mode   (mode[c]),
      .ratio  (ratio[c*CW +: CW]),
      .shift  (shift[c*SW +: SW]),
      .sat_clr(sat_clr[c]),
      .dout   (dout[c*DW +: DW]),
      .dout_en(dout_en[c]),
      .sat    (sat[c])
    );
  end

endmodule

// File: tb/tb_dat_decimate_n.sv
// Randomised self-checking bench for dat_decimate_n against a group-based
// behavioural model (sample lists, floor division, clamp).
module tb_dat_decimate_n;

  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int CW  = 16;
  localparam int SW  = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH*DW-1:0] din;
  logic [NCH-1:0]    din_en;
  logic [NCH-1:0]    ch_en;
  logic [NCH-1:0]    mode;
  logic [NCH*CW-1:0] ratio;
  logic [NCH*SW-1:0] shift;
  logic [NCH*DW-1:0] dout;
  logic [NCH-1:0]    dout_en;
  logic [NCH-1:0]    sat;
  logic [NCH-1:0]    sat_clr;

  int total = 0;
  int bad   = 0;

  // model state
  int          m_n   [NCH];
  longint      m_sum [NCH];
  int          lat_r [NCH];
  logic        lat_m [NCH];
  int          lat_s [NCH];
  logic [15:0] exp_dout [NCH];
  logic        exp_sat  [NCH];
  logic        exp_en   [NCH];

  // observations captured around one strobe
  logic [NCH-1:0]    en_h [1:4];
  logic [NCH*DW-1:0] dout_h4;
  logic [NCH-1:0]    sat_h4;

  always #5 clk = ~clk;

  dat_decimate_n #(.NCH(NCH), .DW(DW), .CW(CW), .SW(SW)) dut (
    .clk    (clk),
    .rst    (rst),
    .din    (din),
    .din_en (din_en),
    .ch_en  (ch_en),
    .mode   (mode),
    .ratio  (ratio),
    .shift  (shift),
    .dout   (dout),
    .dout_en(dout_en),
    .sat    (sat),
    .sat_clr(sat_clr)
  );

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_n[c] = 0; m_sum[c] = 0; lat_r[c] = 1; lat_m[c] = 1'b0; lat_s[c] = 0;
      exp_dout[c] = '0; exp_sat[c] = 1'b0; exp_en[c] = 1'b0;
    end
  endtask

  // Group semantics: collect R samples, then emit the last one or the clamped floor average.
  task automatic model_pulse(input logic [NCH-1:0] m);
    longint smp, d, q;
    for (int c = 0; c < NCH; c++) begin
      exp_en[c] = 1'b0;
      if (!ch_en[c]) begin
        m_n[c] = 0; m_sum[c] = 0;
      end else if (m[c]) begin
        smp = longint'($signed(din[c*DW +: DW]));
        if (m_n[c] == 0) begin
          lat_r[c] = (ratio[c*CW +: CW] == 0) ? 1 : int'(ratio[c*CW +: CW]);
          lat_m[c] = mode[c];
          lat_s[c] = int'(shift[c*SW +: SW]);
        end
        m_n[c]++;
        m_sum[c] += smp;
        if (m_n[c] == lat_r[c]) begin
          exp_en[c] = 1'b1;
          if (lat_m[c] == 1'b0) begin
            exp_dout[c] = 16'(smp);
          end else begin
            d = longint'(1) << lat_s[c];
            q = m_sum[c] / d;
            if ((m_sum[c] % d != 0) && (m_sum[c] < 0)) q = q - 1;
            if (q > 32767) begin q = 32767; exp_sat[c] = 1'b1; end
            if (q < -32768) begin q = -32768; exp_sat[c] = 1'b1; end
            exp_dout[c] = 16'(q);
          end
          m_n[c] = 0; m_sum[c] = 0;
        end
      end
    end
  endtask

  // One strobe period of 4 clocks: rising edge captured at edge k, observations after k..k+3.
  task automatic pulse(input logic [NCH-1:0] m);
    model_pulse(m);
    @(negedge clk);
    din_en = m;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      en_h[i] = dout_en;
      if (i == 2) din_en = '0;
    end
    dout_h4 = dout;
    sat_h4  = sat;
  endtask

  task automatic set_cfg(input int c, input logic md, input int r, input int s);
    mode[c] = md;
    ratio[c*CW +: CW] = CW'(r);
    shift[c*SW +: SW] = SW'(s);
  endtask

  task automatic do_reset();
    din_en = '0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    din = '0; din_en = '0; ch_en = '1; mode = '0; ratio = '0; shift = '0; sat_clr = '0;
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    total++;
    if (dout !== '0 || dout_en !== '0 || sat !== '0) begin
      bad++;
      $display("[TB] FAIL reset_state got dout=%h en=%b sat=%b want 0", dout, dout_en, sat);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_pick();
    int npulse = 0;
    ch_en = 4'b0001;
    set_cfg(0, 1'b0, 4, 0);
    for (int v = 1; v <= 8; v++) begin
      din[15:0] = 16'(v);
      pulse(4'b0001);
      npulse += int'(en_h[1][0]) + int'(en_h[2][0]) + int'(en_h[3][0]) + int'(en_h[4][0]);
      total++;
      if ({en_h[1][0], en_h[2][0], en_h[3][0]} !== 3'b000) begin
        bad++;
        $display("[TB] FAIL pick_early got=%b%b%b want=000", en_h[1][0], en_h[2][0], en_h[3][0]);
      end
      total++;
      if (en_h[4][0] !== exp_en[0]) begin
        bad++;
        $display("[TB] FAIL pick_en v=%0d got=%b want=%b", v, en_h[4][0], exp_en[0]);
      end
      if (v == 4 || v == 8) begin
        total++;
        if (dout_h4[15:0] !== 16'(v) || en_h[4][0] !== 1'b1) begin
          bad++;
          $display("[TB] FAIL pick_dout got=%0d en=%b want=%0d", dout_h4[15:0], en_h[4][0], v);
        end
      end
    end
    total++;
    if (npulse != 2) begin
      bad++;
      $display("[TB] FAIL pick_count got=%0d want=2", npulse);
    end
  endtask

  task automatic test_avg();
    int vals [4] = '{10, 20, 30, 40};
    set_cfg(0, 1'b1, 4, 2);
    for (int i = 0; i < 4; i++) begin
      din[15:0] = 16'(vals[i]);
      pulse(4'b0001);
    end
    total++;
    if (dout_h4[15:0] !== 16'd25 || en_h[4][0] !== 1'b1 || sat_h4[0] !== 1'b0) begin
      bad++;
      $display("[TB] FAIL avg_25 got=%0d en=%b sat=%b want=25/1/0", dout_h4[15:0], en_h[4][0], sat_h4[0]);
    end
    for (int i = 0; i < 4; i++) begin
      din[15:0] = 16'hFFF8;
      pulse(4'b0001);
    end
    total++;
    if (dout_h4[15:0] !== 16'hFFF8 || exp_dout[0] !== 16'hFFF8) begin
      bad++;
      $display("[TB] FAIL avg_neg got=%h model=%h want=fff8", dout_h4[15:0], exp_dout[0]);
    end
  endtask

  task automatic test_saturation();
    set_cfg(0, 1'b1, 4, 0);
    for (int i = 0; i < 4; i++) begin
      din[15:0] = 16'h7FFF;
      pulse(4'b0001);
    end
    total++;
    if (dout_h4[15:0] !== 16'h7FFF || sat_h4[0] !== 1'b1) begin
      bad++;
      $display("[TB] FAIL sat_set got dout=%h sat=%b want 7fff/1", dout_h4[15:0], sat_h4[0]);
    end
    @(negedge clk);
    sat_clr = 4'b0001;
    @(negedge clk);
    sat_clr = '0;
    exp_sat[0] = 1'b0;
    total++;
    if (sat[0] !== 1'b0) begin
      bad++;
      $display("[TB] FAIL sat_clr got=%b want=0", sat[0]);
    end
  endtask

  task automatic test_ratio();
    for (int r = 0; r <= 1; r++) begin
      set_cfg(0, 1'b0, r, 0);
      for (int i = 0; i < 3; i++) begin
        din[15:0] = 16'($urandom_range(0, 65535));
        pulse(4'b0001);
        total++;
        if (en_h[4][0] !== 1'b1 || dout_h4[15:0] !== din[15:0]) begin
          bad++;
          $display("[TB] FAIL ratio%0d got=%h en=%b want=%h", r, dout_h4[15:0], en_h[4][0], din[15:0]);
        end
      end
    end
    set_cfg(0, 1'b0, 4, 0);
    for (int i = 1; i <= 4; i++) begin
      din[15:0] = 16'(100 + i);
      pulse(4'b0001);
      if (i == 1) set_cfg(0, 1'b0, 2, 0);
      total++;
      if (en_h[4][0] !== (i == 4)) begin
        bad++;
        $display("[TB] FAIL ratio_mid i=%0d got=%b want=%b", i, en_h[4][0], (i == 4));
      end
    end
    total++;
    if (dout_h4[15:0] !== 16'd104) begin
      bad++;
      $display("[TB] FAIL ratio_mid_dout got=%0d want=104", dout_h4[15:0]);
    end
  endtask

  task automatic test_reset_mid();
    set_cfg(0, 1'b0, 4, 0);
    for (int i = 0; i < 2; i++) begin
      din[15:0] = 16'(7 + i);
      pulse(4'b0001);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (dout !== '0 || dout_en !== '0 || sat !== '0) begin
      bad++;
      $display("[TB] FAIL rst_mid got dout=%h en=%b sat=%b want 0", dout, dout_en, sat);
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      din[15:0] = 16'(50 + i);
      pulse(4'b0001);
      total++;
      if (en_h[4][0] !== (i == 4)) begin
        bad++;
        $display("[TB] FAIL rst_regroup i=%0d got=%b want=%b", i, en_h[4][0], (i == 4));
      end
    end
  endtask

  task automatic test_multi();
    logic [15:0] held2;
    ch_en = 4'b1111;
    set_cfg(0, 1'b0, 2, 0);
    set_cfg(1, 1'b1, 3, 1);
    set_cfg(2, 1'b0, 1, 0);
    set_cfg(3, 1'b1, 1, 0);
    din = 64'h0004_0003_0002_0001;
    pulse(4'b1111);
    held2 = dout_h4[47:32];
    total++;
    if (held2 !== 16'd3) begin
      bad++;
      $display("[TB] FAIL multi_ch2_first got=%0d want=3", held2);
    end
    @(negedge clk);
    ch_en = 4'b1011;
    for (int p = 0; p < 12; p++) begin
      din = {$urandom, $urandom};
      pulse(4'b1111);
      for (int c = 0; c < NCH; c++) begin
        total++;
        if (en_h[4][c] !== exp_en[c] || dout_h4[c*DW +: DW] !== exp_dout[c] || sat_h4[c] !== exp_sat[c]) begin
          bad++;
          $display("[TB] FAIL multi p=%0d ch=%0d got en=%b d=%h s=%b want en=%b d=%h s=%b", p, c,
                   en_h[4][c], dout_h4[c*DW +: DW], sat_h4[c], exp_en[c], exp_dout[c], exp_sat[c]);
        end
      end
    end
    total++;
    if (dout_h4[47:32] !== held2) begin
      bad++;
      $display("[TB] FAIL multi_ch2_held got=%h want=%h", dout_h4[47:32], held2);
    end
    @(negedge clk);
    ch_en = 4'b1111;
  endtask

  task automatic test_random();
    logic [NCH-1:0] m;
    for (int p = 0; p < 150; p++) begin
      if ($urandom_range(0, 5) == 0) begin
        for (int c = 0; c < NCH; c++)
          set_cfg(c, 1'($urandom), int'($urandom_range(0, 5)), int'($urandom_range(0, 4)));
      end
      if ($urandom_range(0, 20) == 0) begin
        @(negedge clk);
        ch_en = 4'($urandom);
        for (int c = 0; c < NCH; c++)
          if (!ch_en[c]) begin m_n[c] = 0; m_sum[c] = 0; end
      end
      for (int c = 0; c < NCH; c++)
        din[c*DW +: DW] = ($urandom_range(0, 3) == 0) ? 16'h7FF0 : 16'($urandom);
      m = 4'($urandom);
      pulse(m);
      for (int c = 0; c < NCH; c++) begin
        total++;
        if ({en_h[1][c], en_h[2][c], en_h[3][c]} !== 3'b000 || en_h[4][c] !== exp_en[c] ||
            dout_h4[c*DW +: DW] !== exp_dout[c] || sat_h4[c] !== exp_sat[c]) begin
          bad++;
          $display("[TB] FAIL rand p=%0d ch=%0d got en=%b%b%b%b d=%h s=%b want en=000%b d=%h s=%b", p, c,
                   en_h[1][c], en_h[2][c], en_h[3][c], en_h[4][c], dout_h4[c*DW +: DW], sat_h4[c],
                   exp_en[c], exp_dout[c], exp_sat[c]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_pick();
    test_avg();
    test_saturation();
    test_ratio();
    test_reset_mid();
    test_multi();
    do_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
